// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes, controller states and window index helper for the LCD controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE = 4'd0;
    localparam logic [3:0] CMD_UP    = 4'd1;
    localparam logic [3:0] CMD_DOWN  = 4'd2;
    localparam logic [3:0] CMD_LEFT  = 4'd3;
    localparam logic [3:0] CMD_RIGHT = 4'd4;
    localparam logic [3:0] CMD_MAX   = 4'd5;
    localparam logic [3:0] CMD_MIN   = 4'd6;
    localparam logic [3:0] CMD_AVG   = 4'd7;
    localparam logic [3:0] CMD_ROTL  = 4'd8;
    localparam logic [3:0] CMD_ROTR  = 4'd9;
    localparam logic [3:0] CMD_MIRX  = 4'd10;
    localparam logic [3:0] CMD_MIRY  = 4'd11;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WAIT,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } lcd_state_e;

    // Row-major buffer index of pixel (x,y) in an image of width w.
    function automatic int unsigned win_idx(input int unsigned x, input int unsigned y,
                                            input int unsigned w);
        return y * w + x;
    endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational max/min/average of the four window pixels.
// LCD_CTRL_GEN_ROUND_EN selects round-half-up averaging; otherwise the average truncates.
module lcd_win_alu #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] p0_i,
    input  logic [PIX_W-1:0] p1_i,
    input  logic [PIX_W-1:0] p2_i,
    input  logic [PIX_W-1:0] p3_i,
    output logic [PIX_W-1:0] max_o,
    output logic [PIX_W-1:0] min_o,
    output logic [PIX_W-1:0] avg_o
);

    logic [PIX_W-1:0] max01, max23, min01, min23;
    logic [PIX_W+1:0] sum;
    logic [PIX_W+1:0] sum_adj;

    always_comb begin
        max01 = (p0_i > p1_i) ? p0_i : p1_i;
        max23 = (p2_i > p3_i) ? p2_i : p3_i;
        min01 = (p0_i < p1_i) ? p0_i : p1_i;
        min23 = (p2_i < p3_i) ? p2_i : p3_i;
        max_o = (max01 > max23) ? max01 : max23;
        min_o = (min01 < min23) ? min01 : min23;
    end

    // Four PIX_W values plus the rounding constant always fit in PIX_W+2 bits.
    assign sum = (PIX_W+2)'(p0_i) + (PIX_W+2)'(p1_i) + (PIX_W+2)'(p2_i) + (PIX_W+2)'(p3_i);

`ifdef LCD_CTRL_GEN_ROUND_EN
    assign sum_adj = sum + (PIX_W+2)'(2);
`else
    assign sum_adj = sum;
`endif

    assign avg_o = sum_adj[PIX_W+1:2];

endmodule

// File: rtl/lcd_ctrl_gen.sv
// LCD image controller: loads an image from IROM, edits a 2x2 window on host commands,
// streams the buffer to IRAM. Define LCD_CTRL_GEN_ROUND_EN for rounded averaging.
module lcd_ctrl_gen
    import lcd_ctrl_pkg::*;
#(
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    parameter  int PIX_W = 8,
    localparam int N     = IMG_W * IMG_H,
    localparam int AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cmd,
    input  logic             cmd_valid,
    input  logic [PIX_W-1:0] IROM_Q,
    output logic             IROM_rd,
    output logic [AW-1:0]    IROM_A,
    output logic             IRAM_valid,
    output logic [PIX_W-1:0] IRAM_D,
    output logic [AW-1:0]    IRAM_A,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // LOAD  | read IROM into buffer, one extra cycle to capture the last pixel
    // WAIT  | idle, accepting host commands
    // EXEC  | one-cycle busy slot after a non-write command
    // WRITE | stream buffer to IRAM, one pixel per cycle
    // DONE  | done pulse, then reload

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = AW + 1;

    localparam logic [XW-1:0] X_CTR = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_CTR = YW'(IMG_H / 2);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    lcd_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [PIX_W-1:0] buf_q [N];

    logic [AW-1:0]    i0, i1, i2, i3, ld_idx, rd_idx;
    logic [PIX_W-1:0] p0, p1, p2, p3, n0, n1, n2, n3;
    logic [PIX_W-1:0] w_max, w_min, w_avg;
    logic             exec_we, ld_we;

    assign i0 = AW'(win_idx(32'(x_q - XW'(1)), 32'(y_q - YW'(1)), 32'(IMG_W)));
    assign i1 = AW'(win_idx(32'(x_q),          32'(y_q - YW'(1)), 32'(IMG_W)));
    assign i2 = AW'(win_idx(32'(x_q - XW'(1)), 32'(y_q),          32'(IMG_W)));
    assign i3 = AW'(win_idx(32'(x_q),          32'(y_q),          32'(IMG_W)));

    assign p0 = buf_q[i0];
    assign p1 = buf_q[i1];
    assign p2 = buf_q[i2];
    assign p3 = buf_q[i3];

    lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
        .p0_i  (p0),
        .p1_i  (p1),
        .p2_i  (p2),
        .p3_i  (p3),
        .max_o (w_max),
        .min_o (w_min),
        .avg_o (w_avg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        exec_we = 1'b0;
        n0      = p0;
        n1      = p1;
        n2      = p2;
        n3      = p3;
        unique case (state_q)
            ST_LOAD: begin
                if (cnt_q == CW'(N)) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT: begin
                if (cmd_valid) begin
                    if (cmd == CMD_WRITE) begin
                        state_d = ST_WRITE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_EXEC;
                        unique case (cmd)
                            CMD_UP:    if (y_q > YW'(1)) y_d = y_q - YW'(1);
                            CMD_DOWN:  if (y_q < Y_MAX)  y_d = y_q + YW'(1);
                            CMD_LEFT:  if (x_q > XW'(1)) x_d = x_q - XW'(1);
                            CMD_RIGHT: if (x_q < X_MAX)  x_d = x_q + XW'(1);
                            CMD_MAX: begin
                                exec_we = 1'b1;
                                {n0, n1, n2, n3} = {4{w_max}};
                            end
                            CMD_MIN: begin
                                exec_we = 1'b1;
                                {n0, n1, n2, n3} = {4{w_min}};
                            end
                            CMD_AVG: begin
                                exec_we = 1'b1;
                                {n0, n1, n2, n3} = {4{w_avg}};
                            end
                            CMD_ROTL: begin
                                exec_we = 1'b1;
                                {n0, n1, n3, n2} = {p1, p3, p2, p0};
                            end
                            CMD_ROTR: begin
                                exec_we = 1'b1;
                                {n0, n2, n3, n1} = {p2, p3, p1, p0};
                            end
                            CMD_MIRX: begin
                                exec_we = 1'b1;
                                {n0, n2, n1, n3} = {p2, p0, p3, p1};
                            end
                            CMD_MIRY: begin
                                exec_we = 1'b1;
                                {n0, n1, n2, n3} = {p1, p0, p3, p2};
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_EXEC: state_d = ST_WAIT;
            ST_WRITE: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
                x_d     = X_CTR;
                y_d     = Y_CTR;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // ROM data lags its address by one cycle, so LOAD writes the previous address.
    assign ld_we  = (state_q == ST_LOAD) && (cnt_q != '0);
    assign ld_idx = AW'(cnt_q - CW'(1));

    // Image buffer has no reset; only its writers are gated off while reset is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ld_we) begin
                buf_q[ld_idx] <= IROM_Q;
            end
            if (exec_we) begin
                buf_q[i0] <= n0;
                buf_q[i1] <= n1;
                buf_q[i2] <= n2;
                buf_q[i3] <= n3;
            end
        end
    end

    assign rd_idx     = cnt_q[AW-1:0];
    assign IROM_rd    = !reset && (state_q == ST_LOAD) && (cnt_q < CW'(N));
    assign IROM_A     = IROM_rd ? rd_idx : '0;
    assign IRAM_valid = !reset && (state_q == ST_WRITE);
    assign IRAM_A     = IRAM_valid ? rd_idx : '0;
    assign IRAM_D     = IRAM_valid ? buf_q[rd_idx] : '0;
    assign busy       = reset || (state_q != ST_WAIT);
    assign done       = !reset && (state_q == ST_DONE);

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Scoreboard bench for lcd_ctrl_gen: a behavioural image model predicts every IRAM write.
module tb_lcd_ctrl_gen;

    localparam int IMG_W = 8;
    localparam int IMG_H = 8;
    localparam int PIX_W = 8;
    localparam int N     = IMG_W * IMG_H;
    localparam int AW    = $clog2(N);

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       cmd;
    logic             cmd_valid;
    logic [PIX_W-1:0] IROM_Q;
    logic             IROM_rd;
    logic [AW-1:0]    IROM_A;
    logic             IRAM_valid;
    logic [PIX_W-1:0] IRAM_D;
    logic [AW-1:0]    IRAM_A;
    logic             busy;
    logic             done;

    lcd_ctrl_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .IROM_Q     (IROM_Q),
        .IROM_rd    (IROM_rd),
        .IROM_A     (IROM_A),
        .IRAM_valid (IRAM_valid),
        .IRAM_D     (IRAM_D),
        .IRAM_A     (IRAM_A),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec  = 0;
    int  n_err  = 0;
    int  n_done = 0;
    int  rom [N];
    int  img [N];
    int  px, py;

    always @(posedge clk) IROM_Q <= PIX_W'(rom[IROM_A]);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (IRAM_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("iram_extra", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("iram_a", 32'(IRAM_A), 32'(e.a));
                chk("iram_d", 32'(IRAM_D), 32'(e.d));
            end
        end
    end

    task automatic fill_rom(input int pat);
        for (int k = 0; k < N; k++)
            rom[k] = (pat == 0) ? k : int'($urandom_range(0, 255));
    endtask

    task automatic reload_model();
        for (int k = 0; k < N; k++) img[k] = rom[k];
        px = IMG_W / 2;
        py = IMG_H / 2;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
        chk("ready", 32'(busy), 32'd0);
    endtask

    task automatic model_apply(input int cc);
        int i0, i1, i2, i3, a, b, c, d, v;
        i0 = (py - 1) * IMG_W + px - 1;
        i1 = i0 + 1;
        i2 = i0 + IMG_W;
        i3 = i2 + 1;
        a = img[i0]; b = img[i1]; c = img[i2]; d = img[i3];
        case (cc)
            1: if (py > 1) py--;
            2: if (py < IMG_H - 1) py++;
            3: if (px > 1) px--;
            4: if (px < IMG_W - 1) px++;
            5, 6, 7: begin
                if (cc == 5) begin
                    v = a;
                    if (b > v) v = b;
                    if (c > v) v = c;
                    if (d > v) v = d;
                end else if (cc == 6) begin
                    v = a;
                    if (b < v) v = b;
                    if (c < v) v = c;
                    if (d < v) v = d;
                end else begin
`ifdef LCD_CTRL_GEN_ROUND_EN
                    v = (a + b + c + d + 2) / 4;
`else
                    v = (a + b + c + d) / 4;
`endif
                end
                img[i0] = v; img[i1] = v; img[i2] = v; img[i3] = v;
            end
            8:  begin img[i0] = b; img[i1] = d; img[i3] = c; img[i2] = a; end
            9:  begin img[i0] = c; img[i2] = d; img[i3] = b; img[i1] = a; end
            10: begin img[i0] = c; img[i2] = a; img[i1] = d; img[i3] = b; end
            11: begin img[i0] = b; img[i1] = a; img[i2] = d; img[i3] = c; end
            default: ;
        endcase
    endtask

    // A second command is held on cmd_valid during EXEC and must be ignored.
    task automatic send_cmd(input int cc);
        wait_ready();
        cmd       = 4'(cc);
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        cmd = 4'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("exec_free", 32'(busy), 32'd0);
        model_apply(cc);
    endtask

    task automatic do_write(input int next_pat);
        wr_t e;
        wait_ready();
        for (int k = 0; k < N; k++) begin
            e.a = k;
            e.d = img[k];
            exp_q.push_back(e);
        end
        fill_rom(next_pat);
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("wr_first_valid", 32'(IRAM_valid), 32'd1);
        for (int i = 0; i < N + 10 && done !== 1'b1; i++) @(negedge clk);
        chk("done_seen", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_noval", 32'(IRAM_valid), 32'd0);
        chk("wr_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("reload_rd", 32'(IROM_rd), 32'd1);
        chk("reload_a", 32'(IROM_A), 32'd0);
        reload_model();
        wait_ready();
    endtask

    task automatic abort_write();
        wr_t e;
        int  d0;
        wait_ready();
        for (int k = 0; k < N; k++) begin
            e.a = k;
            e.d = img[k];
            exp_q.push_back(e);
        end
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < N + 10 && !(IRAM_valid === 1'b1 && IRAM_A == AW'(20)); i++)
            @(negedge clk);
        chk("abort_k", 32'(IRAM_A), 32'd20);
        #2 reset = 1'b1;
        d0 = n_done;
        @(negedge clk);
        chk("abort_valid", 32'(IRAM_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_rd", 32'(IROM_rd), 32'd0);
        chk("abort_iram_a", 32'(IRAM_A), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_reload_rd", 32'(IROM_rd), 32'd1);
        chk("abort_reload_a", 32'(IROM_A), 32'd0);
        reload_model();
        wait_ready();
        chk("abort_no_done", 32'(n_done), 32'(d0));
    endtask

    initial begin
        int seq [] = '{4, 4, 4, 4, 9, 10, 11, 2, 2, 2, 2, 2, 7, 3, 3, 3, 3, 3, 3, 3, 12, 5, 8, 6, 15, 1};
        reset     = 1'b1;
        cmd       = 4'd0;
        cmd_valid = 1'b0;
        fill_rom(0);
        repeat (3) @(negedge clk);

        chk("rst_irom_rd", 32'(IROM_rd), 32'd0);
        chk("rst_irom_a", 32'(IROM_A), 32'd0);
        chk("rst_iram_valid", 32'(IRAM_valid), 32'd0);
        chk("rst_iram_a", 32'(IRAM_A), 32'd0);
        chk("rst_iram_d", 32'(IRAM_D), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);

        reset = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk);
            chk("load_rd", 32'(IROM_rd), 32'd1);
            chk("load_a", 32'(IROM_A), 32'(k));
            chk("load_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("load_end_rd", 32'(IROM_rd), 32'd0);
        chk("load_end_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("load_ready", 32'(busy), 32'd0);
        reload_model();

        send_cmd(5);
        do_write(0);
        send_cmd(6);
        do_write(0);
        send_cmd(7);
        do_write(0);
        for (int i = 0; i < 4; i++) send_cmd(1);
        send_cmd(8);
        do_write(1);
        foreach (seq[i]) send_cmd(seq[i]);
        do_write(0);
        abort_write();
        send_cmd(11);
        send_cmd(10);
        send_cmd(9);
        do_write(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/lcd_ctrl_gen.md
# lcd_ctrl_gen

Parametrised image controller for the LCD display path. Loads a W×H pixel image from IROM into an internal buffer and executes host commands on a movable 2×2 operation window: shift, max/min/average fill, rotate, mirror. On the write command it streams the buffer to IRAM, pulses done and reloads the next image. Successor of the fixed 8×8 controller, generalised in image size and pixel width.

## Interface
- IMG_W, 8: image width in pixels, ≥2
- IMG_H, 8: image height in pixels, ≥2
- PIX_W, 8: pixel width in bits
- Derived localparams: N = IMG_W*IMG_H; AW = $clog2(N)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd  in  4  command code
- cmd_valid  in  1  command strobe
- IROM_Q  in  PIX_W  ROM read data, valid the cycle after IROM_A
- IROM_rd  out  1  ROM read enable
- IROM_A  out  AW  ROM address
- IRAM_valid  out  1  RAM write strobe
- IRAM_D  out  PIX_W  RAM write data
- IRAM_A  out  AW  RAM write address
- busy  out  1  high: commands ignored
- done  out  1  one-cycle pulse after final IRAM write

## Operation
- Buffer: N×PIX_W, row-major, index = y*IMG_W + x.
- Operation point (x,y), x∈[1,IMG_W-1], y∈[1,IMG_H-1]; reset/reload value (IMG_W/2, IMG_H/2).
- Window: p0=(x-1,y-1), p1=(x,y-1), p2=(x-1,y), p3=(x,y).
- States: LOAD → WAIT → EXEC → WAIT; WAIT → WRITE → DONE → LOAD.
- Command accepted only when cmd_valid && !busy (WAIT); otherwise ignored.
- 0 write: enter WRITE.
- 1/2/3/4 up/down/left/right: y-1 / y+1 / x-1 / x+1, clamped to range (no wrap).
- 5/6/7: p0..p3 ← max / min / average of the four.
- 8 rotate CCW: p0←p1, p1←p3, p3←p2, p2←p0.
- 9 rotate CW: p0←p2, p2←p3, p3←p1, p1←p0.
- 10 mirror X: p0↔p2, p1↔p3. 11 mirror Y: p0↔p1, p2↔p3.
- 12–15: no-op, still one EXEC cycle.
- Average: sum in PIX_W+2 bits, result = sum>>2 (see Configuration); no overflow possible.
- Buffer contents survive reset; only control state clears.

## Timing
- Reset values: IROM_rd=0, IROM_A=0, IRAM_valid=0, IRAM_A=0, IRAM_D=0, busy=1, done=0, state LOAD, point centre.
- LOAD: cycle k=0..N-1 after reset release IROM_rd=1, IROM_A=k; IROM_Q captured into buffer[k] at edge ending cycle k+1. Cycle N: IROM_rd=0. busy first low in cycle N+1.
- Commands 1–15: state update at accepting edge; busy=1 for exactly one cycle (EXEC), low again the cycle after.
- Back-to-back: a command may be accepted every second cycle.
- WRITE: starting cycle after acceptance, N cycles with IRAM_valid=1, IRAM_A=k, IRAM_D=buffer[k]. Next cycle DONE: done=1, IRAM_valid=0, busy=1. Following cycle LOAD restarts at IROM_A=0, point recentred.
- Reset asserted in any state: aborts, outputs to reset values next edge, LOAD restarts on release.

## Configuration
- LCD_CTRL_GEN_ROUND_EN defined: average = (sum+2)>>2 (round half up).
- Undefined: average = sum>>2 (truncate).

## Structure
- Package lcd_ctrl_pkg: command code constants (CMD_WRITE..CMD_MIRY), state enum, window-index helper function.
- Sub-module lcd_win_alu: combinational 4-pixel max/min/average, parametrised by PIX_W, honours LCD_CTRL_GEN_ROUND_EN.

## Test plan
(default 8×8, ROM pixel[k]=k; centre (4,4): p0=27, p1=28, p2=35, p3=36)
- Reset release → IROM_A 0..63 with IROM_rd=1, busy low first in cycle 65.
- cmd 5 → buffer[27,28,35,36]=36; separate run cmd 6 → all 27.
- cmd 7 → all 31; with LCD_CTRL_GEN_ROUND_EN → all 32.
- cmd 1 ×4 → y=1 (clamped), then cmd 8 → buffer[3]=4, buffer[4]=12, buffer[12]=11, buffer[11]=3.
- cmd 0 → 64 IRAM writes IRAM_A=k, IRAM_D=k, done pulse, IROM_A restarts at 0.
- Reset asserted mid-WRITE (k=20) → IRAM_valid=0 next cycle, LOAD restarts, no done pulse.
